// File: rtl/tracklet_div_pkg.sv
// Shared types and constants for the tracklet 30s/16s sequential divider.
package tracklet_div_pkg;

    localparam int DIN0_W = 30;
    localparam int DIN1_W = 16;
    localparam int DOUT_W = 16;

    typedef logic signed [DIN0_W-1:0] dividend_t;
    typedef logic signed [DIN1_W-1:0] divisor_t;
    typedef logic signed [DOUT_W-1:0] quot_t;

    localparam quot_t QUOT_MAX  = quot_t'(32767);
    localparam quot_t QUOT_MIN  = quot_t'(-32768);
    localparam int    DIV_ITERS = DIN0_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tracklet_div_sat.sv
// Sign application and saturation of the unsigned quotient/remainder magnitudes.
// Optional remainder path controlled by TRACKLET_DIV_REM_EN.
module tracklet_div_sat
    import tracklet_div_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DOUT_WIDTH = DOUT_W
) (
    input  logic [DIN0_WIDTH-1:0]        q_mag,
    input  logic                         a_neg,
    input  logic                         b_neg,
    input  logic                         a_zero,
    input  logic                         div_zero,
`ifdef TRACKLET_DIV_REM_EN
    input  logic [DOUT_WIDTH-1:0]        r_mag,
    output logic signed [DOUT_WIDTH-1:0] rem,
`endif
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam logic [DIN0_WIDTH-1:0] POS_LIM = DIN0_WIDTH'((64'd1 << (DOUT_WIDTH-1)) - 64'd1);
    localparam logic [DIN0_WIDTH-1:0] NEG_LIM = DIN0_WIDTH'(64'd1 << (DOUT_WIDTH-1));
    localparam logic [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic                  q_neg;
    logic [DOUT_WIDTH-1:0] q_low;

    assign q_neg = (a_neg ^ b_neg) && (q_mag != '0);
    assign q_low = q_mag[DOUT_WIDTH-1:0];

    // Divide-by-zero overrides everything; otherwise clamp to the signed output range.
    always_comb begin
        dout = '0;
        ovf  = 1'b0;
        if (div_zero) begin
            dout = a_zero ? '0 : (a_neg ? OUT_MIN : OUT_MAX);
        end else if (q_neg) begin
            if (q_mag > NEG_LIM) begin
                dout = OUT_MIN;
                ovf  = 1'b1;
            end else begin
                // magnitude 2^(W-1) negates onto OUT_MIN exactly, no overflow
                dout = -q_low;
            end
        end else begin
            if (q_mag > POS_LIM) begin
                dout = OUT_MAX;
                ovf  = 1'b1;
            end else begin
                dout = q_low;
            end
        end
    end

`ifdef TRACKLET_DIV_REM_EN
    // Remainder follows the dividend sign; with a zero divisor the magnitude
    // already equals |dividend| mod 2^W, so negating yields the truncated dividend.
    always_comb begin
        rem = a_neg ? -r_mag : r_mag;
    end
`endif

endmodule

// File: rtl/tracklet_div_s30_s16_seq.sv
// Sequential signed divider, 30s / 16s -> saturated 16s, radix-2 restoring,
// one quotient bit per cycle. Define TRACKLET_DIV_REM_EN to expose the remainder.
module tracklet_div_s30_s16_seq
    import tracklet_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DIN1_WIDTH = DIN1_W,
    parameter int DOUT_WIDTH = DOUT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    output logic                         dz
`ifdef TRACKLET_DIV_REM_EN
    ,
    output logic signed [DOUT_WIDTH-1:0] rem
`endif
);

    // partial remainder must hold |divisor| up to 2^(DIN1_WIDTH-1)
    localparam int RW = DIN1_WIDTH + 1;
    localparam int CW = $clog2(DIN0_WIDTH);

    state_e                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [DIN0_WIDTH-1:0]         rq_q, rq_d;     // dividend shifts out, quotient shifts in
    logic [RW-1:0]                 r_q, r_d;
    logic [RW-1:0]                 b_q, b_d;
    logic                          a_neg_q, a_neg_d;
    logic                          b_neg_q, b_neg_d;
    logic                          a_zero_q, a_zero_d;
    logic                          div_zero_q, div_zero_d;
    logic signed [DOUT_WIDTH-1:0]  dout_q, dout_d;
    logic                          ovf_q, ovf_d;
    logic                          dz_q, dz_d;
    logic                          out_valid_q, out_valid_d;

    logic [DIN0_WIDTH-1:0]         din0_mag;
    logic signed [RW-1:0]          din1_ext;
    logic [RW-1:0]                 din1_mag;
    logic [RW:0]                   trial;
    logic                          ge;
    logic [RW-1:0]                 diff;
    logic signed [DOUT_WIDTH-1:0]  sat_dout;
    logic                          sat_ovf;

`ifdef TRACKLET_DIV_REM_EN
    logic signed [DOUT_WIDTH-1:0]  rem_q, rem_d;
    logic signed [DOUT_WIDTH-1:0]  sat_rem;
`endif

    // Operand magnitudes; widths chosen so the most negative values are exact.
    always_comb begin
        din1_ext = RW'(din1);
        din0_mag = din0[DIN0_WIDTH-1] ? -din0 : din0;
        din1_mag = din1[DIN1_WIDTH-1] ? -din1_ext : din1_ext;
    end

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        trial = {r_q, rq_q[DIN0_WIDTH-1]};
        ge    = trial >= {1'b0, b_q};
        diff  = trial[RW-1:0] - b_q;
    end

    tracklet_div_sat #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_sat (
        .q_mag    (rq_q),
        .a_neg    (a_neg_q),
        .b_neg    (b_neg_q),
        .a_zero   (a_zero_q),
        .div_zero (div_zero_q),
`ifdef TRACKLET_DIV_REM_EN
        .r_mag    (r_q[DOUT_WIDTH-1:0]),
        .rem      (sat_rem),
`endif
        .dout     (sat_dout),
        .ovf      (sat_ovf)
    );

    // FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rq_d        = rq_q;
        r_d         = r_q;
        b_d         = b_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        a_zero_d    = a_zero_q;
        div_zero_d  = div_zero_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
`ifdef TRACKLET_DIV_REM_EN
        rem_d       = rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_neg_d    = din0[DIN0_WIDTH-1];
                    b_neg_d    = din1[DIN1_WIDTH-1];
                    a_zero_d   = (din0 == '0);
                    div_zero_d = (din1 == '0);
                    rq_d       = din0_mag;
                    r_d        = '0;
                    b_d        = din1_mag;
                    cnt_d      = CW'(DIN0_WIDTH - 1);
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                // zero divisor runs the full count too, keeping latency fixed
                rq_d = {rq_q[DIN0_WIDTH-2:0], ge};
                r_d  = ge ? diff : trial[RW-1:0];
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                dout_d  = sat_dout;
                ovf_d   = sat_ovf;
                dz_d    = div_zero_q;
`ifdef TRACKLET_DIV_REM_EN
                rem_d   = sat_rem;
`endif
                state_d = ST_DONE;
            end
            default: begin
                // result registers settle in FIX; valid is raised one edge later
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rq_q        <= '0;
            r_q         <= '0;
            b_q         <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            a_zero_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef TRACKLET_DIV_REM_EN
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rq_q        <= rq_d;
            r_q         <= r_d;
            b_q         <= b_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            a_zero_q    <= a_zero_d;
            div_zero_q  <= div_zero_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
`ifdef TRACKLET_DIV_REM_EN
            rem_q       <= rem_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
`ifdef TRACKLET_DIV_REM_EN
    assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_tracklet_div_s30_s16_seq.sv
// Directed bench for tracklet_div_s30_s16_seq (remainder checked when TRACKLET_DIV_REM_EN is set).
module tb_tracklet_div_s30_s16_seq;
    import tracklet_div_pkg::*;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [29:0] din0;
    logic signed [15:0] din1;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dout;
    logic               ovf;
    logic               dz;
`ifdef TRACKLET_DIV_REM_EN
    logic signed [15:0] rem;
`endif

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 ap_clk = ~ap_clk;

    tracklet_div_s30_s16_seq #(
        .ID         (1),
        .DIN0_WIDTH (30),
        .DIN1_WIDTH (16),
        .DOUT_WIDTH (16)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .ovf       (ovf),
        .dz        (dz)
`ifdef TRACKLET_DIV_REM_EN
        ,
        .rem       (rem)
`endif
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present operands until accepted, then count edges until out_valid rises.
    task automatic start_op(input int a, input int b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        din0     = 30'(a);
        din1     = 16'(b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (out_valid) break;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".ov_drop"}, out_valid, 0);
        check({tag, ".in_ready"}, in_ready, 1);
    endtask

    task automatic do_vec(input string tag, input int a, input int b, input int exp_q,
                          input int exp_r, input int exp_ovf, input int exp_dz);
        start_op(a, b);
        wait_result(lat);
        check({tag, ".lat"}, lat, 32);
        check({tag, ".dout"}, dout, exp_q);
        check({tag, ".ovf"}, ovf, exp_ovf);
        check({tag, ".dz"}, dz, exp_dz);
`ifdef TRACKLET_DIV_REM_EN
        check({tag, ".rem"}, rem, exp_r);
`else
        if (exp_r == 32'h7fffffff) $display("unreachable");
`endif
        consume(tag);
    endtask

    initial begin
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) tick();
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.dout", dout, 0);
        check("rst.ovf", ovf, 0);
        check("rst.dz", dz, 0);
`ifdef TRACKLET_DIV_REM_EN
        check("rst.rem", rem, 0);
`endif
        ap_rst = 1'b0;
        tick();

        // basic signs
        do_vec("p1000_7",  1000,  7,  142,  6, 0, 0);
        do_vec("n1000_7", -1000,  7, -142, -6, 0, 0);
        do_vec("p1000_n7", 1000, -7, -142,  6, 0, 0);

        // saturation boundaries
        do_vec("sat_pos", 268435456, 3, QUOT_MAX, 1, 1, 0);
        do_vec("sat_neg", -536870912, 1, QUOT_MIN, 0, 1, 0);
        do_vec("neg_exact", -32768, 1, QUOT_MIN, 0, 0, 0);
        do_vec("pos_32768", -32768, -1, QUOT_MAX, 0, 1, 0);

        // divide by zero: remainder is the dividend truncated to 16 bits
        do_vec("dz_pos",  5, 0, QUOT_MAX,  5, 0, 1);
        do_vec("dz_neg", -5, 0, QUOT_MIN, -5, 0, 1);
        do_vec("dz_zero", 0, 0, 0, 0, 0, 1);

        // back-pressure and in_valid ignored while busy: 200/3 = 66 r 2
        start_op(200, 3);
        repeat (5) tick();
        din0     = 30'(77);
        din1     = 16'(1);
        in_valid = 1'b1;
        check("busy.in_ready", in_ready, 0);
        repeat (2) tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("hold.lat", lat, 25);
        for (int i = 0; i < 10; i++) begin
            check("hold.dout", dout, 66);
            check("hold.valid", out_valid, 1);
            check("hold.in_ready", in_ready, 0);
            check("hold.ovf", ovf, 0);
            tick();
        end
`ifdef TRACKLET_DIV_REM_EN
        check("hold.rem", rem, 2);
`endif
        consume("hold");

        // reset during CALC discards the operation
        start_op(1000, 7);
        repeat (15) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 1);
        check("midrst.dout", dout, 0);
        repeat (40) begin
            tick();
            if (out_valid) break;
        end
        check("midrst.no_result", out_valid, 0);

        do_vec("p100_10", 100, 10, 10, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
